// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM state enum,
// default burst cap and the rotating-priority pick function.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_BURST = 16;

    // rr_pick works on a fixed-width vector so one function serves every N up to RR_MAX_N.
    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    // First set bit of valid[n-1:0], scanning upward from ptr with wrap; 0 when none is set.
    function automatic int rr_pick(input logic [RR_MAX_N-1:0] valid, input int ptr, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (!found && valid[idx[RR_IDX_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side write signals of the arbiter, seen from the arbiter
// (slave) and from whoever drives the producers and the FIFO ready (master).
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(N_REQ);

    // A beat moves when valid and ready are both high in the same cycle; valid never waits on ready.
    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_last_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [DATA_WIDTH+ID_W-1:0]  fifo_data_o;
    logic                        fifo_wr_valid_o;
    logic                        fifo_wr_ready_i;

    modport master (
        output req_valid_i, req_last_i, req_data_i, fifo_wr_ready_i,
        input  req_ready_o, fifo_data_o, fifo_wr_valid_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, fifo_wr_ready_i,
        output req_ready_o, fifo_data_o, fifo_wr_valid_o
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational rotating-priority select: first requester at or above the
// pointer, wrapping, as one-hot grant plus encoded index.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [RR_MAX_N-1:0] req_ext;
    int                  pick;

    always_comb begin
        req_ext = RR_MAX_N'(req_i);
        pick    = rr_pick(req_ext, int'(ptr_i), N);
        any_o   = |req_i;
        idx_o   = IDX_W'(pick);
        gnt_o   = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one sync_fifo write port between N_REQ producers.
// Optional FIFO_WR_ARB_BURST_CAP_EN: a grant is also released after MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(N_REQ),  // derived from N_REQ; do not override
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus,
    output logic             busy_o,
    output logic [ID_W-1:0]  owner_o,
    output arb_state_e       state_o
);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       ptr_next;
    logic [DATA_WIDTH-1:0] req_data_a [N_REQ];
    logic [N_REQ-1:0]      idle_gnt_unused;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;
    logic                  own_valid;
    logic                  own_last;
    logic                  handshake;
    logic                  release_grant;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_data_a[k] = bus.req_data_i[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH];
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req_i (bus.req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (idle_gnt_unused),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign own_valid = bus.req_valid_i[owner_q];
    assign own_last  = bus.req_last_i[owner_q];
    assign handshake = (state_q == ARB_GRANT) && own_valid && bus.fifo_wr_ready_i;
    assign ptr_next  = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

`ifdef FIFO_WR_ARB_BURST_CAP_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             cap_hit;

    // The handshake that brings the count to MAX_BURST ends the fragment.
    assign cap_hit       = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    assign release_grant = handshake && (own_last || cap_hit);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if ((state_q != ARB_GRANT) || release_grant) begin
            beat_cnt_d = '0;
        end else if (handshake) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_max_burst;

    assign unused_max_burst = (MAX_BURST == 0);
    assign release_grant    = handshake && own_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
`ifdef FIFO_WR_ARB_BURST_CAP_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef FIFO_WR_ARB_BURST_CAP_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    // The owner keeps the port through valid gaps and FIFO stalls until it releases.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_idx;
                end
            end
            ARB_GRANT: begin
                if (release_grant) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ptr_next;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Zero-latency datapath: everything below follows state_q, so an async reset clears it at once.
    always_comb begin
        busy_o              = 1'b0;
        bus.fifo_wr_valid_o = 1'b0;
        bus.req_ready_o     = '0;
        bus.fifo_data_o     = '0;
        if (state_q == ARB_GRANT) begin
            busy_o                   = 1'b1;
            bus.fifo_wr_valid_o      = own_valid;
            bus.req_ready_o[owner_q] = bus.fifo_wr_ready_i;
            bus.fifo_data_o          = {owner_q, req_data_a[owner_q]};
        end
    end

    assign owner_o = owner_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic checked
// against a packet-queue reference model. Build with FIFO_WR_ARB_BURST_CAP_EN for the cap test.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = $clog2(N);
`ifdef FIFO_WR_ARB_BURST_CAP_EN
    localparam int MB  = 4;
    localparam bit CAP = 1'b1;
`else
    localparam int MB  = 16;
    localparam bit CAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    logic          busy;
    logic [IW-1:0] owner;
    arb_state_e    state;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy_o  (busy),
        .owner_o (owner),
        .state_o (state)
    );

    // ---------------- reference model state ----------------
    logic [DW:0]      beat_q [N][$];   // per producer: {last, data}, front = next beat
    logic [IW+DW-1:0] exp_q [$];       // beats the FIFO must see for the current grant
    int holder;                        // -1 when the port is free
    int rot;                           // first requester considered at the next free cycle
    int run;
    int cyc;

    // observed DUT behaviour, for directed checks
    int   obs_gid [$];
    int   obs_gcyc [$];
    int   obs_fid [$];
    int   obs_flen [$];
    logic obs_busy;
    int   obs_id;
    int   obs_cnt;

    // stimulus knobs
    int         valid_pct;
    int         ready_pct;
    logic [N-1:0] valid_off;
    logic       ready_off;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        holder = -1;
        rot    = 0;
        run    = 0;
        exp_q.delete();
        for (int r = 0; r < N; r++) beat_q[r].delete();
        obs_gid.delete();
        obs_gcyc.delete();
        obs_fid.delete();
        obs_flen.delete();
        obs_busy  = 1'b0;
        obs_id    = 0;
        obs_cnt   = 0;
        valid_pct = 100;
        ready_pct = 100;
        valid_off = '0;
        ready_off = 1'b0;
    endtask

    task automatic zero_inputs();
        bus.req_valid_i     = '0;
        bus.req_last_i      = '0;
        bus.req_data_i      = '0;
        bus.fifo_wr_ready_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     64'(busy),                64'(0));
        check({tag, "_ready"},    64'(bus.req_ready_o),     64'(0));
        check({tag, "_wr_valid"}, 64'(bus.fifo_wr_valid_o), 64'(0));
        check({tag, "_owner"},    64'(owner),               64'(0));
        check({tag, "_state"},    64'(state),               64'(ARB_IDLE));
    endtask

    // Called on a negedge; returns on a later negedge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        zero_inputs();
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) beat_q[r].push_back({(b == len - 1), $urandom()});
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        logic [DW:0] f;
        for (int r = 0; r < N; r++) begin
            f = (beat_q[r].size() != 0) ? beat_q[r][0] : '0;
            bus.req_valid_i[r]         = (beat_q[r].size() != 0) && !valid_off[r] &&
                                         (int'($urandom_range(99)) < valid_pct);
            bus.req_last_i[r]          = f[DW];
            bus.req_data_i[r*DW +: DW] = f[DW-1:0];
        end
        bus.fifo_wr_ready_i = !ready_off && (int'($urandom_range(99)) < ready_pct);
    endtask

    // Free port: rotate from rot to the first valid producer, and queue that
    // producer's beats up to the end of its packet (or the burst cap).
    task automatic grant_model(input logic [N-1:0] v);
        logic [DW:0] f;
        for (int i = 0; i < N; i++) begin
            if (holder < 0 && v[(rot + i) % N]) holder = (rot + i) % N;
        end
        run = 0;
        for (int b = 0; b < beat_q[holder].size(); b++) begin
            f = beat_q[holder][b];
            exp_q.push_back({IW'(holder), f[DW-1:0]});
            if (f[DW] || (CAP && (b + 1 == MB))) break;
        end
    endtask

    task automatic observe();
        if (busy && !obs_busy) begin
            obs_gid.push_back(int'(owner));
            obs_gcyc.push_back(cyc);
            obs_id  = int'(owner);
            obs_cnt = 0;
        end
        if (!busy && obs_busy) begin
            obs_fid.push_back(obs_id);
            obs_flen.push_back(obs_cnt);
        end
        if (busy && bus.fifo_wr_valid_o && bus.fifo_wr_ready_i) obs_cnt++;
        obs_busy = busy;
    endtask

    // ---------------- scoreboard step: one clock cycle ----------------
    task automatic step();
        logic [N-1:0]     v;
        logic             rdy;
        logic [N-1:0]     exp_rdy;
        logic [DW:0]      f;
        logic [IW+DW-1:0] exp_beat;
        drive();
        #1;
        v   = bus.req_valid_i;
        rdy = bus.fifo_wr_ready_i;
        if (holder < 0) begin
            check("idle_busy",     64'(busy),                64'(0));
            check("idle_wr_valid", 64'(bus.fifo_wr_valid_o), 64'(0));
            check("idle_ready",    64'(bus.req_ready_o),     64'(0));
            if (v != '0) grant_model(v);
        end else begin
            exp_rdy = rdy ? (N'(1) << holder) : '0;
            check("busy",     64'(busy),                64'(1));
            check("owner",    64'(owner),               64'(holder));
            check("wr_valid", 64'(bus.fifo_wr_valid_o), 64'(v[holder]));
            check("ready",    64'(bus.req_ready_o),     64'(exp_rdy));
            if (v[holder]) begin
                exp_beat = (exp_q.size() != 0) ? exp_q[0] : '0;
                check("fifo_data", 64'(bus.fifo_data_o), 64'(exp_beat));
                if (rdy) begin
                    void'(exp_q.pop_front());
                    f = beat_q[holder].pop_front();
                    run++;
                    if (f[DW] || (CAP && (run == MB))) begin
                        rot    = (holder + 1) % N;
                        holder = -1;
                    end
                end
            end
        end
        observe();
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    int c0;
    int t2_ids [5] = '{0, 1, 2, 3, 0};
`ifdef FIFO_WR_ARB_BURST_CAP_EN
    int t6_ids [6] = '{0, 1, 0, 1, 0, 1};
    int t6_lens[6] = '{4, 4, 4, 4, 2, 2};
`endif

    initial begin
        cyc = 0;
        model_reset();
        zero_inputs();
        @(negedge clk);

        // single 3-beat packet from requester 0, then rr_ptr must point at 1
        do_reset();
        add_pkt(0, 3);
        c0 = cyc;
        repeat (6) step();
        check("t1_ngrants", 64'(obs_gid.size()),  64'(1));
        check("t1_gid",     64'(obs_gid[0]),      64'(0));
        check("t1_gcyc",    64'(obs_gcyc[0]),     64'(c0 + 1));
        check("t1_flen",    64'(obs_flen[0]),     64'(3));
        add_pkt(0, 1);
        add_pkt(1, 1);
        repeat (6) step();
        check("t1_next_gid", 64'(obs_gid[1]), 64'(1));
        check("t1_then_gid", 64'(obs_gid[2]), 64'(0));

        // all four requesters with 2-beat packets (requester 0 has two)
        do_reset();
        add_pkt(0, 2);
        add_pkt(0, 2);
        for (int r = 1; r < N; r++) add_pkt(r, 2);
        c0 = cyc;
        repeat (18) step();
        check("t2_ngrants", 64'(obs_gid.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_gid%0d", i),  64'(obs_gid[i]),  64'(t2_ids[i]));
            check($sformatf("t2_gcyc%0d", i), 64'(obs_gcyc[i]), 64'(c0 + 1 + 3 * i));
            check($sformatf("t2_flen%0d", i), 64'(obs_flen[i]), 64'(2));
        end

        // FIFO full for 5 cycles in the middle of requester 2's packet
        do_reset();
        add_pkt(2, 4);
        repeat (3) step();
        ready_off = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_ready_stall", 64'(bus.req_ready_o), 64'(0));
            check("t3_owner_stall", 64'(owner),           64'(2));
        end
        ready_off = 1'b0;
        repeat (6) step();
        check("t3_fid",  64'(obs_fid[0]),  64'(2));
        check("t3_flen", 64'(obs_flen[0]), 64'(4));

        // owner 1 goes quiet for 4 cycles while requester 3 waits
        do_reset();
        add_pkt(1, 4);
        add_pkt(3, 2);
        repeat (3) step();
        valid_off[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_ready3_hold", 64'(bus.req_ready_o[3]), 64'(0));
            check("t4_busy_hold",   64'(busy),               64'(1));
        end
        valid_off[1] = 1'b0;
        repeat (10) step();
        check("t4_gid0",  64'(obs_gid[0]),  64'(1));
        check("t4_gid1",  64'(obs_gid[1]),  64'(3));
        check("t4_flen0", 64'(obs_flen[0]), 64'(4));
        check("t4_flen1", 64'(obs_flen[1]), 64'(2));

        // asynchronous reset during beat 2 of a 4-beat packet
        do_reset();
        add_pkt(2, 1);
        repeat (4) step();
        add_pkt(3, 4);
        repeat (2) step();
        drive();
        #1;
        check("t5_busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_async");
        model_reset();
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(3, 1);
        add_pkt(0, 1);
        repeat (6) step();
        check("t5_restart_gid0", 64'(obs_gid[0]), 64'(0));
        check("t5_restart_gid1", 64'(obs_gid[1]), 64'(3));

`ifdef FIFO_WR_ARB_BURST_CAP_EN
        // two 10-beat packets fragmented by the burst cap of 4
        do_reset();
        add_pkt(0, 10);
        add_pkt(1, 10);
        repeat (32) step();
        check("t6_nfrags", 64'(obs_fid.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t6_fid%0d", i),  64'(obs_fid[i]),  64'(t6_ids[i]));
            check($sformatf("t6_flen%0d", i), 64'(obs_flen[i]), 64'(t6_lens[i]));
        end
`endif

        // randomized traffic: gaps on both sides, packets arriving at random times
        do_reset();
        valid_pct = 70;
        ready_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 8) begin
                int r;
                r = int'($urandom_range(N - 1));
                if (beat_q[r].size() < 20) add_pkt(r, int'($urandom_range(6, 1)));
            end
            step();
        end
        valid_pct = 100;
        ready_pct = 100;
        for (int i = 0; i < 400; i++) step();
        check("rand_grants_seen", 64'(obs_gid.size() > 20), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
